// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler
//   Sequences one convolution frame over a shared K-lane multiplier array and
//   an external adder tree. Pixels arrive on an AXI4-Stream slave and fill a
//   KxK window. The window is issued one column per cycle to the multipliers.
//   The final sum is then requested from the adder, and one result per output
//   position is returned on an AXI4-Stream master. TLAST marks the last
//   position of the frame.
//
// Ports
//   axi_clk, axi_reset_n           clock, async active-low reset (sync release)
//   cfg_start/width/height/filter  frame start pulse and frame configuration
//   s_axis_valid/data/ready        pixel stream in (low BIT_LENGTH bits used)
//   mult_a, mult_b, mult_start     per-lane operands and multiply strobes
//   sum_req, sum_valid, sum_data   final-add handshake with the adder tree
//   acc_clear                      one-cycle clear of datapath accumulators
//   m_axis_valid/data/ready/last/keep  result stream out
//   busy, done, cfg_err            status
//
// State table
//   state  | meaning
//   IDLE   | waiting for cfg_start
//   LOAD   | accepting pixel beats into the window
//   MULT   | issuing one window column per cycle, K cycles
//   SUM    | requesting the final add, waiting for sum_valid
//   OUT    | presenting the result until m_axis_ready

module conv_window_scheduler #(
    parameter int BIT_LENGTH  = 32,
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_WIDTH  = 32,
    parameter int DIM_WIDTH   = 16
) (
    input  logic                                        axi_clk,
    input  logic                                        axi_reset_n,
    input  logic                                        cfg_start,
    input  logic [DIM_WIDTH-1:0]                        cfg_width,
    input  logic [DIM_WIDTH-1:0]                        cfg_height,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*BIT_LENGTH-1:0] cfg_filter,
    input  logic                                        s_axis_valid,
    input  logic [DATA_WIDTH-1:0]                       s_axis_data,
    output logic                                        s_axis_ready,
    output logic [KERNEL_SIZE*BIT_LENGTH-1:0]           mult_a,
    output logic [KERNEL_SIZE*BIT_LENGTH-1:0]           mult_b,
    output logic [KERNEL_SIZE-1:0]                      mult_start,
    output logic                                        sum_req,
    input  logic                                        sum_valid,
    input  logic [DATA_WIDTH-1:0]                       sum_data,
    output logic                                        acc_clear,
    output logic                                        m_axis_valid,
    output logic [DATA_WIDTH-1:0]                       m_axis_data,
    input  logic                                        m_axis_ready,
    output logic                                        m_axis_last,
    output logic [DATA_WIDTH/8-1:0]                     m_axis_keep,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        cfg_err
);

    localparam int K     = KERNEL_SIZE;
    localparam int KK    = K * K;
    localparam int BL    = BIT_LENGTH;
    localparam int IDX_W = (KK > 1) ? $clog2(KK) : 1;
    localparam int COL_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [DIM_WIDTH-1:0] K_DIM = DIM_WIDTH'(K);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MULT,
        S_SUM,
        S_OUT
    } state_t;

    // Two-flop synchroniser: reset asserts immediately, releases on a clock edge.
    logic rst_meta_q;
    logic rst_sync_q;

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    state_t                 state_q, state_d;
    logic [DIM_WIDTH-1:0]   width_q, width_d;
    logic [DIM_WIDTH-1:0]   height_q, height_d;
    logic [DIM_WIDTH-1:0]   x_q, x_d;
    logic [DIM_WIDTH-1:0]   y_q, y_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [COL_W-1:0]       col_q, col_d;
    logic [BL-1:0]          window_q [KK];
    logic [BL-1:0]          window_d [KK];
    logic [BL-1:0]          filter_q [KK];
    logic [BL-1:0]          filter_d [KK];
    logic [K*BL-1:0]        mult_a_hold_q, mult_a_hold_d;
    logic [K*BL-1:0]        mult_b_hold_q, mult_b_hold_d;
    logic [DATA_WIDTH-1:0]  sum_q, sum_d;
    logic                   cfg_err_q, cfg_err_d;
    logic                   done_q, done_d;
    logic                   acc_clear_q, acc_clear_d;

    logic [K*BL-1:0]        col_a;
    logic [K*BL-1:0]        col_b;
    logic [IDX_W-1:0]       base_idx;
    logic [IDX_W-1:0]       lane_idx;
    logic [DIM_WIDTH-1:0]   x_max;
    logic [DIM_WIDTH-1:0]   y_max;
    logic                   last_pos;

    assign x_max    = width_q - K_DIM;
    assign y_max    = height_q - K_DIM;
    assign last_pos = (x_q == x_max) && (y_q == y_max);

    // Current window column: lane i carries element c*K+i (column-major window).
    always_comb begin
        col_a    = '0;
        col_b    = '0;
        lane_idx = '0;
        base_idx = IDX_W'(col_q) * IDX_W'(K);
        for (int i = 0; i < K; i++) begin
            lane_idx            = base_idx + IDX_W'(i);
            col_a[i*BL +: BL]   = window_q[lane_idx];
            col_b[i*BL +: BL]   = filter_q[lane_idx];
        end
    end

    // Operands follow the active column during MULT and hold their last value otherwise.
    assign mult_a        = (state_q == S_MULT) ? col_a : mult_a_hold_q;
    assign mult_b        = (state_q == S_MULT) ? col_b : mult_b_hold_q;
    assign mult_a_hold_d = mult_a;
    assign mult_b_hold_d = mult_b;
    assign mult_start    = {K{state_q == S_MULT}};

    assign s_axis_ready  = (state_q == S_LOAD);
    assign sum_req       = (state_q == S_SUM) && !sum_valid;
    assign m_axis_valid  = (state_q == S_OUT);
    assign m_axis_data   = sum_q;
    assign m_axis_last   = (state_q == S_OUT) && last_pos;
    assign m_axis_keep   = {(DATA_WIDTH/8){m_axis_valid}};
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign cfg_err       = cfg_err_q;
    assign acc_clear     = acc_clear_q;

    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        height_d    = height_q;
        x_d         = x_q;
        y_d         = y_q;
        ptr_d       = ptr_q;
        col_d       = col_q;
        sum_d       = sum_q;
        cfg_err_d   = cfg_err_q;
        done_d      = 1'b0;
        acc_clear_d = 1'b0;
        for (int n = 0; n < KK; n++) begin
            window_d[n] = window_q[n];
            filter_d[n] = filter_q[n];
        end

        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    width_d  = cfg_width;
                    height_d = cfg_height;
                    for (int n = 0; n < KK; n++) begin
                        filter_d[n] = cfg_filter[n*BL +: BL];
                    end
                    if ((cfg_width < K_DIM) || (cfg_height < K_DIM)) begin
                        cfg_err_d = 1'b1;
                        done_d    = 1'b1;
                    end else begin
                        cfg_err_d = 1'b0;
                        x_d       = '0;
                        y_d       = '0;
                        ptr_d     = '0;
                        state_d   = S_LOAD;
                    end
                end
            end

            S_LOAD: begin
                if (s_axis_valid) begin
                    window_d[ptr_q] = s_axis_data[BL-1:0];
                    if (ptr_q == IDX_W'(KK - 1)) begin
                        col_d   = '0;
                        state_d = S_MULT;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end

            S_MULT: begin
                if (col_q == COL_W'(K - 1)) begin
                    // Slide one column left so the next position only needs K new beats.
                    for (int j = 0; j < KK - K; j++) begin
                        window_d[j] = window_q[j+K];
                    end
                    col_d   = '0;
                    state_d = S_SUM;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end

            S_SUM: begin
                if (sum_valid) begin
                    sum_d   = sum_data;
                    state_d = S_OUT;
                end
            end

            S_OUT: begin
                if (m_axis_ready) begin
                    acc_clear_d = 1'b1;
                    if (last_pos) begin
                        done_d  = 1'b1;
                        x_d     = '0;
                        y_d     = '0;
                        state_d = S_IDLE;
                    end else if (x_q == x_max) begin
                        x_d     = '0;
                        y_d     = y_q + DIM_WIDTH'(1);
                        ptr_d   = '0;
                        state_d = S_LOAD;
                    end else begin
                        x_d     = x_q + DIM_WIDTH'(1);
                        ptr_d   = IDX_W'(KK - K);
                        state_d = S_LOAD;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q       <= S_IDLE;
            width_q       <= '0;
            height_q      <= '0;
            x_q           <= '0;
            y_q           <= '0;
            ptr_q         <= '0;
            col_q         <= '0;
            sum_q         <= '0;
            cfg_err_q     <= 1'b0;
            done_q        <= 1'b0;
            acc_clear_q   <= 1'b0;
            mult_a_hold_q <= '0;
            mult_b_hold_q <= '0;
            for (int n = 0; n < KK; n++) begin
                window_q[n] <= '0;
                filter_q[n] <= '0;
            end
        end else begin
            state_q       <= state_d;
            width_q       <= width_d;
            height_q      <= height_d;
            x_q           <= x_d;
            y_q           <= y_d;
            ptr_q         <= ptr_d;
            col_q         <= col_d;
            sum_q         <= sum_d;
            cfg_err_q     <= cfg_err_d;
            done_q        <= done_d;
            acc_clear_q   <= acc_clear_d;
            mult_a_hold_q <= mult_a_hold_d;
            mult_b_hold_q <= mult_b_hold_d;
            for (int n = 0; n < KK; n++) begin
                window_q[n] <= window_d[n];
                filter_q[n] <= filter_d[n];
            end
        end
    end

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Directed bench for conv_window_scheduler (K=3). A small adder model
// accumulates the lane products and answers sum_req after a programmable delay.

module tb_conv_window_scheduler;

    localparam int BL = 32;
    localparam int K  = 3;
    localparam int DW = 32;
    localparam int DIMW = 16;

    logic               axi_clk = 1'b0;
    logic               axi_reset_n = 1'b1;
    logic               cfg_start = 1'b0;
    logic [DIMW-1:0]    cfg_width = '0;
    logic [DIMW-1:0]    cfg_height = '0;
    logic [K*K*BL-1:0]  cfg_filter = '0;
    logic               s_axis_valid = 1'b0;
    logic [DW-1:0]      s_axis_data = '0;
    logic               s_axis_ready;
    logic [K*BL-1:0]    mult_a;
    logic [K*BL-1:0]    mult_b;
    logic [K-1:0]       mult_start;
    logic               sum_req;
    logic               sum_valid = 1'b0;
    logic [DW-1:0]      sum_data = '0;
    logic               acc_clear;
    logic               m_axis_valid;
    logic [DW-1:0]      m_axis_data;
    logic               m_axis_ready = 1'b0;
    logic               m_axis_last;
    logic [DW/8-1:0]    m_axis_keep;
    logic               busy;
    logic               done;
    logic               cfg_err;

    conv_window_scheduler #(
        .BIT_LENGTH (BL),
        .KERNEL_SIZE(K),
        .DATA_WIDTH (DW),
        .DIM_WIDTH  (DIMW)
    ) dut (
        .axi_clk     (axi_clk),
        .axi_reset_n (axi_reset_n),
        .cfg_start   (cfg_start),
        .cfg_width   (cfg_width),
        .cfg_height  (cfg_height),
        .cfg_filter  (cfg_filter),
        .s_axis_valid(s_axis_valid),
        .s_axis_data (s_axis_data),
        .s_axis_ready(s_axis_ready),
        .mult_a      (mult_a),
        .mult_b      (mult_b),
        .mult_start  (mult_start),
        .sum_req     (sum_req),
        .sum_valid   (sum_valid),
        .sum_data    (sum_data),
        .acc_clear   (acc_clear),
        .m_axis_valid(m_axis_valid),
        .m_axis_data (m_axis_data),
        .m_axis_ready(m_axis_ready),
        .m_axis_last (m_axis_last),
        .m_axis_keep (m_axis_keep),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    always #5 axi_clk = ~axi_clk;

    int vectors = 0;
    int miscompares = 0;

    // Adder model state and event counters (observed at the falling edge).
    logic [DW-1:0] acc = '0;
    int sum_delay = 1;
    int req_cnt = 0;
    int mult_cyc = 0;
    int sumreq_cyc = 0;
    int clr_cnt = 0;
    int done_cnt = 0;
    int beat_cnt = 0;
    int mout_cnt = 0;

    always @(negedge axi_clk) begin
        if (!axi_reset_n) begin
            acc = '0;
        end else begin
            if (acc_clear) acc = '0;
            if (|mult_start) begin
                for (int i = 0; i < K; i++) begin
                    acc = acc + DW'(mult_a[i*BL +: BL] * mult_b[i*BL +: BL]);
                end
            end
            mult_cyc   += int'(|mult_start);
            sumreq_cyc += int'(sum_req);
            clr_cnt    += int'(acc_clear);
            done_cnt   += int'(done);
            beat_cnt   += int'(s_axis_valid && s_axis_ready);
            mout_cnt   += int'(m_axis_valid && m_axis_ready);
        end
    end

    // sum_valid answers on the (sum_delay+1)-th SUM cycle, so sum_req is seen high sum_delay cycles.
    always begin
        @(posedge axi_clk);
        #1;
        sum_valid = 1'b0;
        if (!axi_reset_n) begin
            req_cnt = 0;
        end else begin
            #1;
            if (sum_req) begin
                if (req_cnt >= sum_delay) begin
                    sum_valid = 1'b1;
                    sum_data  = acc;
                    req_cnt   = 0;
                end else begin
                    req_cnt++;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input int w, input int h, input logic [K*K*BL-1:0] filt);
        cfg_width  = DIMW'(w);
        cfg_height = DIMW'(h);
        cfg_filter = filt;
        cfg_start  = 1'b1;
        step();
        cfg_start  = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] v, input bit gap);
        int n;
        n = 0;
        s_axis_data  = v;
        s_axis_valid = 1'b1;
        while (!s_axis_ready && n < 200) begin
            step();
            n++;
        end
        if (!s_axis_ready) begin
            chk("beat_timeout", 64'(s_axis_ready), 64'd1);
            s_axis_valid = 1'b0;
            return;
        end
        step();
        s_axis_valid = 1'b0;
        if (gap) step();
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!m_axis_valid && n < 100) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, 64'(m_axis_valid), 64'd1);
    endtask

    task automatic expect_out(input string tag, input logic [DW-1:0] exp_data, input logic exp_last);
        wait_valid(tag);
        if (!m_axis_valid) return;
        chk({tag, "_data"}, 64'(m_axis_data), 64'(exp_data));
        chk({tag, "_last"}, 64'(m_axis_last), 64'(exp_last));
        chk({tag, "_keep"}, 64'(m_axis_keep), 64'hf);
        m_axis_ready = 1'b1;
        step();
        m_axis_ready = 1'b0;
    endtask

    logic [K*K*BL-1:0] ones;
    logic [K*K*BL-1:0] ramp;
    int b_beat, b_mult, b_sreq, b_clr, b_done, b_mout;

    task automatic snap();
        b_beat = beat_cnt;
        b_mult = mult_cyc;
        b_sreq = sumreq_cyc;
        b_clr  = clr_cnt;
        b_done = done_cnt;
        b_mout = mout_cnt;
    endtask

    initial begin
        for (int n = 0; n < K*K; n++) begin
            ones[n*BL +: BL] = 32'd1;
            ramp[n*BL +: BL] = 32'(n + 1);
        end

        // Reset state
        #3;
        axi_reset_n = 1'b0;
        #20;
        chk("rst_busy",    64'(busy), 64'd0);
        chk("rst_ready",   64'(s_axis_ready), 64'd0);
        chk("rst_mvalid",  64'(m_axis_valid), 64'd0);
        chk("rst_mstart",  64'(mult_start), 64'd0);
        chk("rst_sumreq",  64'(sum_req), 64'd0);
        chk("rst_done_err_clr", {61'd0, done, cfg_err, acc_clear}, 64'd0);
        chk("rst_keep_last", {59'd0, m_axis_keep, m_axis_last}, 64'd0);
        chk("rst_mult_a",  64'(|mult_a), 64'd0);
        @(negedge axi_clk);
        axi_reset_n = 1'b1;
        repeat (4) step();

        // Frame A: W=4,H=3, filter ones. Windows 1..9 -> 45, 4..12 -> 72.
        snap();
        sum_delay = 1;
        start_frame(4, 3, ones);
        chk("a_busy", 64'(busy), 64'd1);
        chk("a_err",  64'(cfg_err), 64'd0);
        for (int v = 1; v <= 9; v++) send_beat(DW'(v), 1'b0);
        chk("a_ready_drop", 64'(s_axis_ready), 64'd0);
        chk("a_beats9", 64'(beat_cnt - b_beat), 64'd9);
        wait_valid("a0_pre");
        // Stall the result; offer the next pixel and a stray start meanwhile.
        s_axis_data  = 32'd10;
        s_axis_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("a0_hold", 64'(m_axis_data), 64'd45);
            cfg_width = 16'd9;
            cfg_start = (i == 2);
            step();
        end
        cfg_start = 1'b0;
        chk("a0_no_beat", 64'(beat_cnt - b_beat), 64'd9);
        chk("a0_mult3", 64'(mult_cyc - b_mult), 64'd3);
        expect_out("a0", 32'd45, 1'b0);
        s_axis_valid = 1'b0;
        send_beat(32'd10, 1'b0);
        send_beat(32'd11, 1'b0);
        send_beat(32'd12, 1'b0);
        expect_out("a1", 32'd72, 1'b1);
        chk("a_done_hi", 64'(done), 64'd1);
        chk("a_idle", 64'(busy), 64'd0);
        step();
        chk("a_done_lo", 64'(done), 64'd0);
        chk("a_done_cnt", 64'(done_cnt - b_done), 64'd1);
        chk("a_clr_cnt",  64'(clr_cnt - b_clr), 64'd2);
        chk("a_mult6",    64'(mult_cyc - b_mult), 64'd6);
        chk("a_outs",     64'(mout_cnt - b_mout), 64'd2);
        chk("a_beats12",  64'(beat_cnt - b_beat), 64'd12);

        // Frame B: W=H=3, ramp filter, toggling valid, adder 7 cycles late. 1^2+..+9^2 = 285.
        snap();
        sum_delay = 7;
        start_frame(3, 3, ramp);
        for (int v = 1; v <= 9; v++) send_beat(DW'(v), 1'b1);
        chk("b_beats9", 64'(beat_cnt - b_beat), 64'd9);
        expect_out("b0", 32'd285, 1'b1);
        step();
        chk("b_mult3",  64'(mult_cyc - b_mult), 64'd3);
        chk("b_sumreq7", 64'(sumreq_cyc - b_sreq), 64'd7);
        chk("b_done_cnt", 64'(done_cnt - b_done), 64'd1);
        chk("b_beats_after", 64'(beat_cnt - b_beat), 64'd9);

        // Frame C: W=2 is too narrow for K=3.
        snap();
        sum_delay = 1;
        start_frame(2, 5, ones);
        chk("c_err",   64'(cfg_err), 64'd1);
        chk("c_done",  64'(done), 64'd1);
        chk("c_busy",  64'(busy), 64'd0);
        chk("c_ready", 64'(s_axis_ready), 64'd0);
        step();
        chk("c_done_lo", 64'(done), 64'd0);
        chk("c_err_sticky", 64'(cfg_err), 64'd1);
        s_axis_valid = 1'b1;
        repeat (3) step();
        s_axis_valid = 1'b0;
        chk("c_no_beats", 64'(beat_cnt - b_beat), 64'd0);
        chk("c_no_outs",  64'(mout_cnt - b_mout), 64'd0);

        // Frame D: reset during MULT, then a clean 3x3 frame.
        snap();
        start_frame(3, 3, ones);
        chk("d_err_clr", 64'(cfg_err), 64'd0);
        for (int v = 1; v <= 9; v++) send_beat(DW'(v + 100), 1'b0);
        chk("d_in_mult", 64'(mult_start), 64'h7);
        axi_reset_n = 1'b0;
        #1;
        chk("d_rst_mstart", 64'(mult_start), 64'd0);
        chk("d_rst_busy",   64'(busy), 64'd0);
        chk("d_rst_mult_a", 64'(|mult_a), 64'd0);
        chk("d_rst_misc", {59'd0, m_axis_valid, m_axis_last, sum_req, done, s_axis_ready}, 64'd0);
        repeat (2) step();
        axi_reset_n = 1'b1;
        repeat (4) step();
        chk("d_no_done", 64'(done_cnt - b_done), 64'd0);
        start_frame(3, 3, ones);
        for (int v = 1; v <= 9; v++) send_beat(DW'(v), 1'b0);
        expect_out("d0", 32'd45, 1'b1);
        chk("d_done", 64'(done), 64'd1);
        step();
        chk("d_done_cnt", 64'(done_cnt - b_done), 64'd1);
        chk("d_outs", 64'(mout_cnt - b_mout), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
